// File: rtl/fft4_load_ctrl.sv
// Serial-to-parallel loader for a 4-point FFT: gathers four samples into a fill
// bank and hands complete frames to a registered output bank (lanes a1..d1).
// Optional macro FFT4_BITREV_EN loads lanes in bit-reversed order (a1, c1, b1, d1).
//
// state | meaning
// FILL0 | waiting for sample 0 of a frame
// FILL1 | waiting for sample 1
// FILL2 | waiting for sample 2
// FILL3 | waiting for sample 3; transfer to output bank on acceptance if free
// FULL  | four samples held, output bank occupied; input stalled
module fft4_load_ctrl #(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a1,
  output logic [DATA_W-1:0] b1,
  output logic [DATA_W-1:0] c1,
  output logic [DATA_W-1:0] d1,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [2:0] {
    FILL0 = 3'd0,
    FILL1 = 3'd1,
    FILL2 = 3'd2,
    FILL3 = 3'd3,
    FULL  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fill_q [4];
  logic [DATA_W-1:0] fill_d [4];
  logic [DATA_W-1:0] out_q  [4];
  logic              out_valid_q;
  logic [7:0]        frame_cnt_q;

  logic       accept;
  logic       consume;
  logic       xfer;
  logic [1:0] wr_lane;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FILL0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q != FULL);
    consume  = out_valid_q && out_ready;
    // A flush in the same cycle wins over any acceptance.
    accept   = in_valid && in_ready && !flush;
    xfer     = 1'b0;
    case (state_q)
      FILL0:   if (accept) state_d = FILL1;
      FILL1:   if (accept) state_d = FILL2;
      FILL2:   if (accept) state_d = FILL3;
      FILL3: begin
        if (accept) begin
          if (!out_valid_q || out_ready) begin
            xfer    = 1'b1;
            state_d = FILL0;
          end else begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (consume && !flush) begin
          xfer    = 1'b1;
          state_d = FILL0;
        end
      end
      default: state_d = FILL0;
    endcase
    if (flush) state_d = FILL0;
  end

`ifdef FFT4_BITREV_EN
  assign wr_lane = {state_q[0], state_q[1]};
`else
  assign wr_lane = state_q[1:0];
`endif

  // Next fill-bank contents; the transfer copies this so the 4th sample lands in the same edge.
  always_comb begin
    for (int i = 0; i < 4; i++) fill_d[i] = fill_q[i];
    if (flush) begin
      for (int i = 0; i < 4; i++) fill_d[i] = '0;
    end else if (accept) begin
      fill_d[wr_lane] = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        fill_q[i] <= '0;
        out_q[i]  <= '0;
      end
      out_valid_q <= 1'b0;
      frame_cnt_q <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) fill_q[i] <= fill_d[i];
      if (xfer) begin
        for (int i = 0; i < 4; i++) out_q[i] <= fill_d[i];
        out_valid_q <= 1'b1;
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
      if (consume) frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign out_valid = out_valid_q;
  assign a1        = out_q[0];
  assign b1        = out_q[1];
  assign c1        = out_q[2];
  assign d1        = out_q[3];
  assign frame_cnt = frame_cnt_q;

endmodule
